// File: rtl/dmem_io_pkg.sv
// Shared types and constants for the dmem_io_sequencer load/run/unload block.
package dmem_io_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_LOAD_WORDS   = 1000;
    localparam int DEF_UNLOAD_WORDS = 997;
    localparam int DEF_RD_LATENCY   = 1;

    localparam logic [1:0] MUX_CORES = 2'd0;
    localparam logic [1:0] MUX_LOAD  = 2'd1;
    localparam logic [1:0] MUX_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START_P,
        S_WAIT_END,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_OUT
    } state_e;

endpackage

// File: rtl/dmem_io_rd_delay.sv
// Valid shift register: tap rises RD_LATENCY cycles after start, marking the
// cycle in which the memory read data for the presented address is valid.
module dmem_io_rd_delay #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic tap
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("dmem_io_rd_delay: RD_LATENCY must be in 1..4");
    end

    logic [RD_LATENCY-1:0] pipe_q;
    logic [RD_LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = start;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tap = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/dmem_io_sequencer.sv
// Loads a word stream into data memory, pulses START, waits for END and
// streams the result region back. Optional macro: DMEM_IO_CYCLE_COUNT_EN.
module dmem_io_sequencer
    import dmem_io_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LOAD_WORDS   = DEF_LOAD_WORDS,
    parameter int UNLOAD_WORDS = DEF_UNLOAD_WORDS,
    parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        addr_mux_select,
    output logic [ADDR_W-1:0] current_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              write_from_tb,
    output logic [ADDR_W-1:0] ar_in,
    output logic              START,
    input  logic              END,
    input  logic [DATA_W-1:0] dmem_out_disp,
    output logic              busy,
    output logic              done
`ifdef DMEM_IO_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam longint MAX_WORDS = longint'(1) << ADDR_W;
    if (LOAD_WORDS > MAX_WORDS || UNLOAD_WORDS > MAX_WORDS) begin : g_bad_size
        $error("dmem_io_sequencer: word count exceeds address space");
    end

    // Last-index compares let a full 2^ADDR_W region run without the counter wrapping.
    localparam logic [ADDR_W-1:0] LD_LAST = ADDR_W'(LOAD_WORDS > 0 ? LOAD_WORDS - 1 : 0);
    localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(UNLOAD_WORDS > 0 ? UNLOAD_WORDS - 1 : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                wr_q, wr_d;
    logic                ld_last_q, ld_last_d;
    logic                rd_start;
    logic                rd_tap;

    dmem_io_rd_delay #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_delay (
        .clk  (clk),
        .rst  (RESET),
        .start(rd_start),
        .tap  (rd_tap)
    );

    always_comb begin
        state_d         = state_q;
        ld_cnt_d        = ld_cnt_q;
        rd_cnt_d        = rd_cnt_q;
        cur_addr_d      = cur_addr_q;
        mem_data_d      = mem_data_q;
        out_data_d      = out_data_q;
        wr_d            = 1'b0;
        ld_last_d       = ld_last_q;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        addr_mux_select = MUX_CORES;
        ar_in           = '0;
        START           = 1'b0;
        done            = 1'b0;
        rd_start        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ld_cnt_d  = '0;
                    ld_last_d = 1'b0;
                    rd_cnt_d  = '0;
                    state_d   = (LOAD_WORDS == 0) ? S_START_P : S_LOAD;
                end
            end
            S_LOAD: begin
                addr_mux_select = MUX_LOAD;
                in_ready        = !wr_q;
                // Leave only once the final strobe has actually been presented.
                if (wr_q) begin
                    if (ld_last_q) state_d = S_START_P;
                end else if (in_valid) begin
                    mem_data_d = in_data;
                    cur_addr_d = ld_cnt_q;
                    wr_d       = 1'b1;
                    ld_last_d  = (ld_cnt_q == LD_LAST);
                    if (ld_cnt_q != LD_LAST) ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            S_START_P: begin
                START   = 1'b1;
                state_d = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (END) begin
                    if (UNLOAD_WORDS == 0) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_cnt_d = '0;
                        state_d  = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                addr_mux_select = MUX_READ;
                ar_in           = rd_cnt_q;
                rd_start        = 1'b1;
                state_d         = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                addr_mux_select = MUX_READ;
                ar_in           = rd_cnt_q;
                if (rd_tap) begin
                    out_data_d = dmem_out_disp;
                    state_d    = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                addr_mux_select = MUX_READ;
                ar_in           = rd_cnt_q;
                out_valid       = 1'b1;
                if (out_ready) begin
                    if (rd_cnt_q == RD_LAST) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = S_RD_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            cur_addr_q <= '0;
            mem_data_q <= '0;
            out_data_q <= '0;
            wr_q       <= 1'b0;
            ld_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            cur_addr_q <= cur_addr_d;
            mem_data_q <= mem_data_d;
            out_data_q <= out_data_d;
            wr_q       <= wr_d;
            ld_last_q  <= ld_last_d;
        end
    end

    assign current_addr  = cur_addr_q;
    assign mem_data      = mem_data_q;
    assign write_from_tb = wr_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != S_IDLE);

`ifdef DMEM_IO_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == S_START_P) begin
            cyc_cnt_d = '0;
        end else if (state_q == S_WAIT_END && cyc_cnt_q != '1) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cycle_count = cyc_cnt_q;
`endif

endmodule
